// File: rtl/dequant_pkg.sv
// Shared constants and frame-state encoding for the Q2.14 -> Q18.14 row dequantizer.
package dequant_pkg;

    localparam int Q2_14_FRAC  = 14;
    localparam int Q18_14_FRAC = 14;
    localparam int IN_W        = 16;
    localparam int OUT_W       = 32;
    localparam int DEF_SHIFT   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/row_fifo2.sv
// Two-entry synchronous FIFO holding whole rows; flush empties it in one cycle.
module row_fifo2 #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign do_push = i_push && (count != 2'd2);
    assign do_pop  = i_pop  && (count != 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the storage is reset because the head is visible on the output
            // and must read as zero out of reset; with only two entries this is cheap.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (i_flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign o_count = count;
    assign o_head  = mem[rd_ptr];

endmodule

// File: rtl/dequantize_rows_to_q18_14.sv
// Widens Q2.14 softmax rows to Q18.14 (x8 scale restore), buffers two rows,
// and tags each output row with its index within the frame.
module dequantize_rows_to_q18_14
    import dequant_pkg::*;
#(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int IN_W   = dequant_pkg::IN_W,
    parameter int OUT_W  = dequant_pkg::OUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [COLS-1:0][IN_W-1:0]  i_row,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [COLS-1:0][OUT_W-1:0] o_row,
    output logic [IDX_W-1:0]           o_row_idx,
    output logic                       o_last,
    output logic                       o_frame_done
);

    if (SHIFT > 15) begin : g_shift_check
        $error("SHIFT above 15 overflows the Q18.14 range");
    end

    logic [COLS-1:0][OUT_W-1:0] conv_row;
    logic [1:0]                 count;
    logic                       push;
    logic                       pop;
    state_e                     state, state_n;
    logic [IDX_W-1:0]           out_idx, out_idx_n;
    logic                       at_last;

    // Sign-extend then shift: the widened range makes saturation unnecessary.
    for (genvar c = 0; c < COLS; c++) begin : g_conv
        assign conv_row[c] = {{(OUT_W-IN_W){i_row[c][IN_W-1]}}, i_row[c]} << SHIFT;
    end

    assign o_ready = (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    row_fifo2 #(
        .W (COLS*OUT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (conv_row),
        .o_count (count),
        .o_head  (o_row)
    );

    assign at_last = (out_idx == IDX_W'(ROWS-1));

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        out_idx_n = out_idx;
        unique case (state)
            IDLE, DONE: begin
                if (pop) begin
                    state_n   = (ROWS == 1) ? DONE : STREAM;
                    out_idx_n = (ROWS == 1) ? '0 : IDX_W'(1);
                end else begin
                    state_n   = IDLE;
                    out_idx_n = '0;
                end
            end
            STREAM: begin
                if (pop) begin
                    state_n   = at_last ? DONE : STREAM;
                    out_idx_n = at_last ? '0 : out_idx + IDX_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                out_idx_n = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            state   <= IDLE;
            out_idx <= '0;
        end else begin
            state   <= state_n;
            out_idx <= out_idx_n;
        end
    end

    assign o_row_idx    = out_idx;
    assign o_last       = o_valid && at_last;
    assign o_frame_done = (state == DONE);

endmodule

// File: tb/tb_dequantize_rows_to_q18_14.sv
// Self-checking bench: constant vector table, directed frame/backpressure/flush/reset
// sequences, and a queue-based scoreboard fed by randomized rows.
module tb_dequantize_rows_to_q18_14;

    localparam int ROWS  = 32;
    localparam int COLS  = 32;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int SHIFT = 3;
    localparam int IDX_W = $clog2(ROWS);

    typedef logic [COLS-1:0][IN_W-1:0]  in_row_t;
    typedef logic [COLS-1:0][OUT_W-1:0] out_row_t;
    typedef struct {
        logic [IN_W-1:0]  in_val;
        logic [OUT_W-1:0] exp_val;
    } vec_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    in_row_t          i_row;
    logic             o_valid;
    logic             i_ready;
    out_row_t         o_row;
    logic [IDX_W-1:0] o_row_idx;
    logic             o_last;
    logic             o_frame_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_cnt     = 0;
    int last_cnt     = 0;
    bit mon_en       = 1'b0;
    bit seen_full    = 1'b0;

    out_row_t exp_q[$];
    int       exp_idx  = 0;
    bit       exp_done = 1'b0;

    dequantize_rows_to_q18_14 #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_row        (i_row),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_row        (o_row),
        .o_row_idx    (o_row_idx),
        .o_last       (o_last),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_row(input string name, input out_row_t act, input out_row_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            for (int c = 0; c < COLS; c++) begin
                if (act[c] !== exp[c]) begin
                    $display("FAIL %s: col %0d got %h expected %h (cycle %0d)",
                             name, c, act[c], exp[c], cyc);
                    break;
                end
            end
        end
    endtask

    // Reference: plain signed arithmetic, value times 2^SHIFT.
    function automatic out_row_t model_row(input in_row_t r);
        out_row_t m;
        for (int c = 0; c < COLS; c++) begin
            m[c] = OUT_W'(int'($signed(r[c])) * (2 ** SHIFT));
        end
        return m;
    endfunction

    function automatic in_row_t rand_row();
        in_row_t r;
        for (int c = 0; c < COLS; c++) r[c] = IN_W'($urandom);
        return r;
    endfunction

    function automatic in_row_t fill_row(input logic [IN_W-1:0] v);
        in_row_t r;
        for (int c = 0; c < COLS; c++) r[c] = v;
        return r;
    endfunction

    // Scoreboard: compare visible outputs, then predict the effect of the coming edge.
    always @(negedge i_clk) begin
        if (mon_en) begin
            check("mon_valid", o_valid, exp_q.size() != 0);
            check("mon_ready", o_ready, exp_q.size() != 2);
            check("mon_frame_done", o_frame_done, exp_done);
            if (exp_q.size() != 0) begin
                check_row("mon_row", o_row, exp_q[0]);
                check("mon_idx", o_row_idx, exp_idx);
                check("mon_last", o_last, exp_idx == ROWS-1);
            end
            if (o_frame_done) done_cnt++;
            if (o_valid && o_last) last_cnt++;
            if (!o_ready) seen_full = 1'b1;

            if (!i_rst_n || i_flush) begin
                exp_q.delete();
                exp_idx  = 0;
                exp_done = 1'b0;
            end else begin
                bit do_pop;
                bit do_push;
                do_pop   = (exp_q.size() != 0) && i_ready;
                do_push  = i_valid && (exp_q.size() != 2);
                exp_done = 1'b0;
                if (do_pop) begin
                    void'(exp_q.pop_front());
                    if (exp_idx == ROWS-1) begin
                        exp_idx  = 0;
                        exp_done = 1'b1;
                    end else begin
                        exp_idx++;
                    end
                end
                if (do_push) exp_q.push_back(model_row(i_row));
            end
        end
    end

    // Holds i_valid until the row is taken; returns 1 time unit after the accepting edge.
    task automatic send_row(input in_row_t r);
        bit acc;
        int t;
        acc     = 1'b0;
        t       = 0;
        i_valid = 1'b1;
        i_row   = r;
        while (!acc && t < 100) begin
            @(negedge i_clk);
            acc = o_ready && !i_flush;
            @(posedge i_clk);
            #1;
            t++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (o_valid && t < 50) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain_empty", o_valid, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_ready"}, o_ready, 1'b1);
        check_row({tag, "_row"}, o_row, '0);
        check({tag, "_idx"}, o_row_idx, 0);
        check({tag, "_last"}, o_last, 1'b0);
        check({tag, "_done"}, o_frame_done, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        int c0, d0, l0;
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_row   = '0;

        vecs[0] = '{16'h4000, 32'h0002_0000};
        vecs[1] = '{16'h8000, 32'hFFFC_0000};
        vecs[2] = '{16'h7FFF, 32'h0003_FFF8};
        vecs[3] = '{16'hFFFF, 32'hFFFF_FFF8};
        vecs[4] = '{16'h0000, 32'h0000_0000};
        vecs[5] = '{16'hC000, 32'hFFFE_0000};

        step(1);
        mon_en = 1'b1;
        step(2);
        check_reset_values("reset");

        // Constant vectors: one-cycle latency, index follows row order.
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_row(fill_row(vecs[i].in_val));
            check("vec_valid", o_valid, 1'b1);
            check("vec_col0", o_row[0], vecs[i].exp_val);
            check("vec_colN", o_row[COLS-1], vecs[i].exp_val);
            check("vec_idx", o_row_idx, i);
        end
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        step(1);

        // Full frame back to back: one row per cycle, one last, one done pulse.
        d0 = done_cnt;
        l0 = last_cnt;
        c0 = cyc;
        for (int i = 0; i < ROWS; i++) send_row(rand_row());
        check("frame_cycles", cyc - c0, ROWS);
        drain();
        step(2);
        check("frame_done_pulses", done_cnt - d0, 1);
        check("frame_last_rows", last_cnt - l0, 1);

        // Backpressure: downstream stalls for 5 cycles mid-stream.
        seen_full = 1'b0;
        fork
            for (int i = 0; i < 10; i++) send_row(rand_row());
            begin
                step(3);
                i_ready = 1'b0;
                step(5);
                i_ready = 1'b1;
            end
        join
        drain();
        check("bp_ready_dropped", seen_full, 1'b1);

        // Flush coincident with a valid row after row 10.
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        for (int i = 0; i < 11; i++) send_row(rand_row());
        d0 = done_cnt;
        i_valid = 1'b1;
        i_row   = rand_row();
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_empty", o_valid, 1'b0);
        step(3);
        check("flush_no_done", done_cnt - d0, 0);
        send_row(fill_row(16'h2000));
        check("flush_next_idx", o_row_idx, 0);
        check("flush_next_val", o_row[3], 32'h0001_0000);
        drain();

        // Reset (with flush high) mid-frame, then a clean full frame.
        for (int i = 0; i < 5; i++) send_row(rand_row());
        i_rst_n = 1'b0;
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_row   = rand_row();
        step(1);
        check_reset_values("midrst");
        i_rst_n = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < ROWS; i++) send_row(rand_row());
        drain();
        step(2);
        check("rst_frame_done", done_cnt - d0, 1);

        // Random traffic against random downstream readiness.
        fork
            for (int i = 0; i < 40; i++) begin
                send_row(rand_row());
                step($urandom_range(0, 2));
            end
            begin
                repeat (150) begin
                    i_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
                i_ready = 1'b1;
            end
        join
        i_ready = 1'b1;
        drain();
        step(2);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dequantize_rows_to_q18_14.md
# dequantize_rows_to_q18_14

Streaming widener that converts softmax-domain Q2.14 matrix rows back into the systolic-array Q18.14 domain, undoing the 1/8 attention scale. It sits between the softmax output and the second SA matmul (probability × V), accepting one row per beat under valid/ready. It buffers rows in a 2-entry FIFO, tags each output row with its index, and flags frame completion.

## Interface
Parameters:
- ROWS, 32, rows per matrix (frame)
- COLS, 32, elements per row
- IN_W, 16, input element width (Q2.14)
- OUT_W, 32, output element width (Q18.14)
- SHIFT, 3, left-shift applied after sign extension (×8)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst_n  in  1  synchronous, active-low reset
- i_flush  in  1  abort current frame; clears FIFO and counters
- i_valid  in  1  input row valid
- o_ready  out  1  input row accepted when i_valid && o_ready
- i_row  in  COLS×IN_W (signed, packed [COLS-1:0][IN_W-1:0])  Q2.14 row
- o_valid  out  1  output row valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_row  out  COLS×OUT_W (signed, packed)  Q18.14 row
- o_row_idx  out  $clog2(ROWS)  index of row on o_row
- o_last  out  1  o_row_idx == ROWS-1 while o_valid
- o_frame_done  out  1  one-cycle pulse after the last row of a frame is handed off

## Operation
- Per element: sign-extend IN_W to OUT_W, then arithmetic shift left by SHIFT. No saturation needed: |value| ≤ 2^15·2^SHIFT fits OUT_W for SHIFT ≤ 15; SHIFT > 15 is illegal (elaboration assertion).
- Conversion happens at FIFO write; FIFO stores converted OUT_W rows.
- FIFO: 2 entries, count 0..2; push on input handshake, pop on output handshake; simultaneous push+pop keeps count unchanged.
- o_ready = (count != 2). No combinational path from i_ready to o_ready.
- o_valid = (count != 0); o_row = head entry.
- Frame FSM, states IDLE, STREAM, DONE:
  - IDLE: out_idx = 0; first output handshake → STREAM (or DONE if ROWS == 1).
  - STREAM: each output handshake increments out_idx; the handshake with out_idx == ROWS-1 → DONE.
  - DONE: o_frame_done = 1 for exactly one cycle, out_idx = 0 → IDLE. Output may continue with the next frame's row 0 during DONE; that handshake → STREAM.
- i_flush (sync): count ← 0, out_idx ← 0, FSM ← IDLE, no o_frame_done; any handshake in the same cycle is discarded (flush wins).
- i_rst_n low overrides i_flush.

## Timing
- Reset values: o_valid 0, o_ready 1 (count 0 after reset), o_row 0, o_row_idx 0, o_last 0, o_frame_done 0.
- Latency: row accepted at edge N appears on o_row with o_valid from cycle N+1.
- Throughput: 1 row/cycle sustained when i_ready stays high.
- Backpressure: with i_ready low, 2 rows are accepted, then o_ready drops the next cycle. o_row is stable while o_valid && !i_ready.
- o_frame_done is asserted the cycle after the last-row handshake.
- Reset or flush mid-frame: the next accepted row is output as row_idx 0.

## Structure
- Package dequant_pkg: Q2_14_FRAC = 14, Q18_14_FRAC = 14, IN_W, OUT_W, default SHIFT, and typedef state_e {IDLE, STREAM, DONE}.
- Sub-module row_fifo2: parameterized width, 2-entry synchronous FIFO with push, pop, flush, count, and head outputs.
- Top level holds the conversion logic (generate over COLS) and the frame FSM.

## Test plan
- Reset then a single row of all 16'h4000 (1.0) → o_row elements 32'h0002_0000 (8.0), o_row_idx 0, latency 1 cycle.
- Extremes: elements 16'h8000 → 32'hFFFC_0000; 16'h7FFF → 32'h0003_FFF8; 16'hFFFF → 32'hFFFF_FFF8.
- 32 back-to-back rows with i_ready = 1 → 32 consecutive o_valid cycles, o_row_idx 0..31, o_last only on row 31, o_frame_done exactly one cycle later.
- Backpressure: i_ready = 0 for 5 cycles during streaming → o_ready low once count = 2, no row lost or duplicated, order preserved, o_row stable.
- i_flush asserted after row 10, coincident with i_valid → that row is dropped, no o_frame_done, next row emerges as idx 0.
- i_rst_n low for 1 cycle mid-frame with i_flush high → all outputs at reset values, then a fresh frame completes normally.
